updown_counter_bounded: RTL

UPDOWN_COUNTER_BOUNDED -- requirements
Module: updown_counter_bounded

---
 rtl/updown_counter_pkg.sv | 17 +
 rtl/updown_counter_next.sv | 82 ++++++++
 rtl/updown_counter_bounded.sv | 126 ++++++++++++
 3 files changed

// File: rtl/updown_counter_pkg.sv
// Shared definitions for the bounded up/down counter.
//   mode_e          : counting mode encoding (value 3 is reserved and behaves as SAT)
//   DEFAULT_WIDTH   : default counter width
//   DEFAULT_STEP_W  : default step input width
package updown_counter_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STEP_W = 8;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_SAT      = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-state computation for one enabled count.
// Ports:
//   value, lo, hi   : current count and inclusive bounds
//   step            : unsigned increment, zero-extended to WIDTH
//   inst            : requested direction (0 up, 1 down), ignored in PINGPONG
//   mode            : counting mode
//   dir_q           : current PINGPONG direction register
//   next_value      : count after this step
//   next_dir        : PINGPONG direction after this step
//   cross_up/dn     : the step crossed hi / lo
//   tc_hit          : count newly lands on lo or hi
import updown_counter_pkg::*;

module updown_counter_next #(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STEP_W = DEFAULT_STEP_W
) (
  input  logic [WIDTH-1:0]  value,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [STEP_W-1:0] step,
  input  logic              inst,
  input  mode_e             mode,
  input  logic              dir_q,
  output logic [WIDTH-1:0]  next_value,
  output logic              next_dir,
  output logic              cross_up,
  output logic              cross_dn,
  output logic              tc_hit
);

  // One extra bit so neither value+step nor lo+step can wrap.
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] sum_up;
  logic [WIDTH:0] lo_plus;
  logic           in_range;
  logic           count_up;
  logic           is_wrap;
  logic           is_pp;

  assign step_x   = (WIDTH+1)'(step);
  assign sum_up   = {1'b0, value} + step_x;
  assign lo_plus  = {1'b0, lo} + step_x;
  assign in_range = (value >= lo) && (value <= hi);
  assign is_wrap  = (mode == MODE_WRAP);
  assign is_pp    = (mode == MODE_PINGPONG);
  assign count_up = is_pp ? ~dir_q : ~inst;

  always_comb begin
    next_value = value;
    next_dir   = dir_q;
    cross_up   = 1'b0;
    cross_dn   = 1'b0;
    tc_hit     = 1'b0;
    if (step_x != '0) begin
      if (!in_range) begin
        // Out-of-bounds count snaps back to lo silently.
        next_value = lo;
      end else if (count_up) begin
        if (sum_up > {1'b0, hi}) begin
          cross_up   = 1'b1;
          next_value = is_wrap ? lo : hi;
          if (is_pp) next_dir = 1'b1;
        end else begin
          next_value = sum_up[WIDTH-1:0];
        end
      end else begin
        if ({1'b0, value} < lo_plus) begin
          cross_dn   = 1'b1;
          next_value = is_wrap ? hi : lo;
          if (is_pp) next_dir = 1'b0;
        end else begin
          next_value = value - step_x[WIDTH-1:0];
        end
      end
      // Only a fresh arrival at a bound pulses; a saturated hold does not.
      tc_hit = in_range && (next_value != value) &&
               ((next_value == lo) || (next_value == hi));
    end
  end

endmodule

// File: rtl/updown_counter_bounded.sv
// Bounded up/down counter with WRAP, SAT and PINGPONG modes.
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   en, inst, mode   : count enable, direction (0 up / 1 down), mode select
//   step             : unsigned increment
//   lo, hi           : inclusive bounds (lo>hi flags cfg_err and blocks counting)
//   load, load_val   : clamped load, higher priority than en
//   clr_flags        : clears sticky ovf/unf (a same-cycle set wins)
//   value            : registered count
//   dir              : effective direction
//   at_lo, at_hi     : value equals lo / hi
//   tc               : registered terminal-count pulse
//   ovf, unf         : sticky overflow / underflow
//   cfg_err          : lo > hi
import updown_counter_pkg::*;

module updown_counter_bounded #(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STEP_W = DEFAULT_STEP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              inst,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  value,
  output logic              dir,
  output logic              at_lo,
  output logic              at_hi,
  output logic              tc,
  output logic              ovf,
  output logic              unf,
  output logic              cfg_err
);

  logic [WIDTH-1:0] value_q, value_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  mode_e            mode_m;
  logic [WIDTH-1:0] nx_value;
  logic             nx_dir;
  logic             nx_cross_up;
  logic             nx_cross_dn;
  logic             nx_tc;
  logic [WIDTH-1:0] load_hi;
  logic [WIDTH-1:0] load_clamped;
  logic             do_count;

  assign mode_m = mode_e'(mode);

  updown_counter_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .value      (value_q),
    .lo         (lo),
    .hi         (hi),
    .step       (step),
    .inst       (inst),
    .mode       (mode_m),
    .dir_q      (dir_q),
    .next_value (nx_value),
    .next_dir   (nx_dir),
    .cross_up   (nx_cross_up),
    .cross_dn   (nx_cross_dn),
    .tc_hit     (nx_tc)
  );

  // Clamp to hi first, then lo, so a bad config (lo>hi) still yields lo.
  assign load_hi      = (load_val > hi) ? hi : load_val;
  assign load_clamped = (load_hi < lo) ? lo : load_hi;

  assign cfg_err  = (lo > hi);
  assign do_count = en && !load && !cfg_err;

  always_comb begin
    value_d = value_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~clr_flags;
    unf_d   = unf_q & ~clr_flags;
    if (load) begin
      value_d = load_clamped;
    end else if (do_count) begin
      value_d = nx_value;
      dir_d   = nx_dir;
      tc_d    = nx_tc;
      if (nx_cross_up) ovf_d = 1'b1;
      if (nx_cross_dn) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= '0;
      dir_q   <= 1'b0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign value = value_q;
  assign dir   = (mode_m == MODE_PINGPONG) ? dir_q : inst;
  assign at_lo = (value_q == lo);
  assign at_hi = (value_q == hi);
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule
